// File: rtl/inner_prod_seq.sv
// Time-multiplexed signed fixed-point inner product: one LANES-wide chunk per cycle
// through multiply / lane-sum / accumulate stages, then rescale and saturate.
module inner_prod_seq #(
    parameter int DATA_LEN = 16,
    parameter int LEN      = 288,
    parameter int LANES    = 36,
    parameter int FRAC     = 8,
    parameter int ACC_LEN  = 48
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         accum,
    input  logic [LEN*DATA_LEN-1:0]      d1,
    input  logic [LEN*DATA_LEN-1:0]      d2,
    output logic                         busy,
    output logic                         valid,
    output logic signed [DATA_LEN-1:0]   q,
    output logic                         sat
);

    localparam int NCHUNK = LEN / LANES;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PROD_W = 2 * DATA_LEN;
    localparam int SUM_W  = 2 * DATA_LEN + $clog2(LANES);

    localparam logic signed [ACC_LEN-1:0] R_MAX =
        {{(ACC_LEN-DATA_LEN+1){1'b0}}, {(DATA_LEN-1){1'b1}}};
    localparam logic signed [ACC_LEN-1:0] R_MIN =
        {{(ACC_LEN-DATA_LEN+1){1'b1}}, {(DATA_LEN-1){1'b0}}};

    generate
        if (LEN % LANES != 0) begin : g_len_check
            $error("inner_prod_seq: LEN must be a multiple of LANES");
        end
        if (ACC_LEN < 2 * DATA_LEN + $clog2(LEN)) begin : g_acc_check
            $error("inner_prod_seq: ACC_LEN too narrow for LEN products");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t                       state;
    logic [LEN*DATA_LEN-1:0]      a_r;
    logic [LEN*DATA_LEN-1:0]      b_r;
    logic [IDX_W-1:0]             idx;
    logic [1:0]                   dcnt;
    logic                         p_vld;
    logic                         s_vld;
    logic signed [PROD_W-1:0]     prod_c [LANES];
    logic signed [PROD_W-1:0]     prod_r [LANES];
    logic signed [SUM_W-1:0]      sum_c;
    logic signed [SUM_W-1:0]      sum_r;
    logic signed [ACC_LEN-1:0]    acc;
    logic signed [ACC_LEN-1:0]    r;
    logic                         finish;
    logic                         accept;

    // The final drain edge also accepts start, so chained runs issue every NCHUNK+3 cycles.
    assign finish = (state == DRAIN) && (dcnt == 2'd2);
    assign accept = start && ((state == IDLE) || finish);

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            int unsigned base;
            logic signed [PROD_W-1:0] ea;
            logic signed [PROD_W-1:0] eb;
            base = (32'(idx) * LANES + l) * DATA_LEN;
            ea = PROD_W'($signed(a_r[base +: DATA_LEN]));
            eb = PROD_W'($signed(b_r[base +: DATA_LEN]));
            prod_c[l] = ea * eb;
        end
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            sum_c = sum_c + SUM_W'(prod_r[l]);
        end
    end

    assign r = acc >>> FRAC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            idx   <= '0;
            dcnt  <= '0;
            p_vld <= 1'b0;
            s_vld <= 1'b0;
            for (int unsigned l = 0; l < LANES; l++) begin
                prod_r[l] <= '0;
            end
            sum_r <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            q     <= '0;
            sat   <= 1'b0;
        end else begin
            p_vld <= 1'b0;
            s_vld <= p_vld;
            sum_r <= sum_c;
            valid <= 1'b0;

            if (s_vld) begin
                acc <= acc + ACC_LEN'(sum_r);
            end

            case (state)
                IDLE: ;
                LOAD, RUN: begin
                    prod_r <= prod_c;
                    p_vld  <= 1'b1;
                    if (idx == IDX_W'(NCHUNK - 1)) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= RUN;
                    end
                end
                DRAIN: begin
                    if (finish) begin
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (r > R_MAX) begin
                            q   <= {1'b0, {(DATA_LEN-1){1'b1}}};
                            sat <= 1'b1;
                        end else if (r < R_MIN) begin
                            q   <= {1'b1, {(DATA_LEN-1){1'b0}}};
                            sat <= 1'b1;
                        end else begin
                            q   <= r[DATA_LEN-1:0];
                            sat <= 1'b0;
                        end
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                a_r   <= d1;
                b_r   <= d2;
                idx   <= '0;
                busy  <= 1'b1;
                state <= LOAD;
                if (!accum) begin
                    acc <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_inner_prod_seq.sv
// Directed bench for inner_prod_seq at default parameters: vector table plus
// chaining, handshake and mid-run reset sequences.
module tb_inner_prod_seq;

    localparam int DW  = 16;
    localparam int LEN = 288;
    localparam int VW  = LEN * DW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 accum = 1'b0;
    logic [VW-1:0]        d1 = '0;
    logic [VW-1:0]        d2 = '0;
    logic                 busy;
    logic                 valid;
    logic signed [DW-1:0] q;
    logic                 sat;

    int checks = 0;
    int errors = 0;

    inner_prod_seq #(.DATA_LEN(16), .LEN(288), .LANES(36), .FRAC(8), .ACC_LEN(48)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .accum (accum),
        .d1    (d1),
        .d2    (d2),
        .busy  (busy),
        .valid (valid),
        .q     (q),
        .sat   (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                name;
        logic signed [DW-1:0] a_val;
        logic signed [DW-1:0] b_val;
        bit                   b_first_only;
        int                   exp_q;
        int                   exp_sat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] fill(input logic signed [DW-1:0] v, input bit first_only);
        logic [VW-1:0] res;
        for (int i = 0; i < LEN; i++) begin
            res[i*DW +: DW] = (first_only && i != 0) ? '0 : v;
        end
        return res;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] res;
        for (int i = 0; i < LEN; i++) begin
            res[i*DW +: DW] = 16'($urandom);
        end
        return res;
    endfunction

    // Drives start for one edge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [VW-1:0] a, input logic [VW-1:0] b, input bit acc_in);
        @(negedge clk);
        d1 = a;
        d2 = b;
        accum = acc_in;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    vec_t vecs[6];
    int   n;
    int   nvalid;
    int   q_seen;

    initial begin
        vecs[0] = '{"basic",     16'sd256,  16'sd256, 1'b1, 256,    0};
        vecs[1] = '{"neg",       -16'sd256, 16'sd8,   1'b0, -2304,  0};
        vecs[2] = '{"trunc_pos", 16'sd1,    16'sd1,   1'b0, 1,      0};
        vecs[3] = '{"trunc_neg", -16'sd1,   16'sd1,   1'b0, -2,     0};
        vecs[4] = '{"sat_pos",   16'sd256,  16'sd256, 1'b0, 32767,  1};
        vecs[5] = '{"sat_neg",   -16'sd256, 16'sd256, 1'b0, -32768, 1};

        #1;
        check("reset_q", int'(q), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_sat", int'(sat), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            launch(fill(vecs[i].a_val, 1'b0), fill(vecs[i].b_val, vecs[i].b_first_only), 1'b0);
            check({vecs[i].name, "_busy"}, int'(busy), 1);
            wait_valid(n);
            check({vecs[i].name, "_latency"}, n, 11);
            check({vecs[i].name, "_q"}, int'(q), vecs[i].exp_q);
            check({vecs[i].name, "_sat"}, int'(sat), vecs[i].exp_sat);
            @(negedge clk);
            check({vecs[i].name, "_valid_pulse"}, int'(valid), 0);
            check({vecs[i].name, "_idle"}, int'(busy), 0);
        end

        // Chaining: second start held across the edge that produces the first valid.
        launch(fill(16'sd16, 1'b0), fill(16'sd16, 1'b0), 1'b0);
        repeat (10) @(negedge clk);
        accum = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("chain1_valid", int'(valid), 1);
        check("chain1_q", int'(q), 288);
        check("chain1_busy", int'(busy), 1);
        @(negedge clk);
        n = 1;
        while (!valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("chain2_gap", n, 11);
        check("chain2_q", int'(q), 576);
        check("chain2_sat", int'(sat), 0);

        // Handshake: mid-run starts ignored, inputs scrambled after acceptance.
        launch(fill(16'sd256, 1'b0), fill(16'sd256, 1'b1), 1'b0);
        n = 0;
        nvalid = 0;
        q_seen = 0;
        while (n < 30) begin
            if (n == 1) begin
                d1 = rand_vec();
                d2 = rand_vec();
            end
            start = (n == 3 || n == 6);
            if (start) begin
                d1 = fill(16'sd256, 1'b0);
                d2 = fill(16'sd256, 1'b0);
            end
            @(negedge clk);
            n++;
            if (valid) begin
                nvalid++;
                q_seen = int'(q);
            end
        end
        start = 1'b0;
        check("hs_valid_count", nvalid, 1);
        check("hs_q", q_seen, 256);

        // Reset mid-run with a large accumulator, then chain onto the cleared state.
        launch(fill(16'sd256, 1'b0), fill(16'sd256, 1'b0), 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_q", int'(q), 0);
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_sat", int'(sat), 0);
        nvalid = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        check("mid_rst_no_valid", nvalid, 0);
        launch(fill(16'sd256, 1'b0), fill(16'sd256, 1'b1), 1'b1);
        wait_valid(n);
        check("post_rst_latency", n, 11);
        check("post_rst_q", int'(q), 256);
        check("post_rst_sat", int'(sat), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inner_prod_seq.md
# inner_prod_seq

Time-multiplexed signed fixed-point inner product of two `LEN`-element vectors. Each cycle it processes one `LANES`-wide chunk through a multiply / adder-tree / accumulate pipeline, then rescales and saturates the result to `DATA_LEN` bits. It generalises the fixed 288-element, 36-lane inner product with four additions: parametrised length, lane count and fraction bits; a start/valid handshake; saturation reporting; and chained accumulation for vectors longer than `LEN`. It sits between the feature/weight buffers and the activation stage.

## Interface
- `DATA_LEN`, 16, signed element width (two's complement).
- `LEN`, 288, vector length. Must be a multiple of `LANES`; elaboration fails otherwise.
- `LANES`, 36, multipliers instantiated. `NCHUNK = LEN/LANES` (8 at defaults).
- `FRAC`, 8, fractional bits per element. The result is arithmetically shifted right by `FRAC`; 0 means no shift.
- `ACC_LEN`, 48, accumulator width. Must be ≥ `2*DATA_LEN + clog2(LEN)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled on a rising edge while idle.
- `accum`  in  1  sampled with `start`. 1: keep the accumulator from the previous run. 0: clear it.
- `d1`  in  `LEN*DATA_LEN`  vector A; element i at bits `[i*DATA_LEN +: DATA_LEN]`.
- `d2`  in  `LEN*DATA_LEN`  vector B; same packing.
- `busy`  out  1  run in progress.
- `valid`  out  1  one-cycle pulse; `q` and `sat` are updated on the same edge.
- `q`  out  `DATA_LEN`  signed result, held until the next `valid`.
- `sat`  out  1  1 when the latest `q` was clipped; held with `q`.

## Operation
- States: IDLE → LOAD → RUN → DRAIN → IDLE.
- IDLE: `start`=1 latches `d1`, `d2` into operand registers, sets `idx`=0, latches `accum`, and moves to LOAD. Inputs may change afterwards.
- LOAD/RUN: `idx` steps 0..NCHUNK-1, one chunk per cycle.
  - Stage P registers `LANES` full-width products of chunk `idx` (2*DATA_LEN bits each).
  - Stage S registers the signed lane sum, width `2*DATA_LEN+clog2(LANES)`.
  - Stage A: `acc <= acc + sign_ext(S)`.
- The accumulator is cleared at the start edge when `accum`=0; it is untouched when `accum`=1.
- DRAIN: waits for the last chunk to reach stage A.
- Output: `r = acc >>> FRAC` (truncation toward −∞).
  - `r > 2^(DATA_LEN-1)-1` → `q` = max, `sat`=1.
  - `r < -2^(DATA_LEN-1)` → `q` = min, `sat`=1.
  - otherwise `q = r`, `sat`=0.
- Accumulator overflow beyond `ACC_LEN` wraps silently; the caller bounds the chain length.
- `start` while `busy`=1 is ignored; there is no queueing.

## Timing
- Let T0 be the edge that accepts `start`.
  - `busy` rises at T0.
  - Stage P loads chunk k at T0+1+k.
  - Stage S loads chunk k at T0+2+k.
  - Stage A adds chunk k at T0+3+k.
- At T0+NCHUNK+3 (T0+11 at defaults): `valid`=1, `q`/`sat` update, `busy`=0, state returns to IDLE.
- `valid` lasts exactly one cycle.
- `start` sampled in the cycle where `valid`=1 is accepted, giving back-to-back runs every NCHUNK+3 cycles. That cycle's `accum`=1 chains onto the result just produced.
- Reset (any time, including mid-run) asynchronously clears:
  - `q`=0, `valid`=0, `busy`=0, `sat`=0;
  - `acc`, `idx`, stage P/S to 0; state to IDLE.
  - An in-flight run is discarded and no `valid` is issued for it.
- First `start` is accepted on the first edge after `rst_n` deasserts.

## Test plan
All cases use default parameters.
- **Basic:** `d1` all 256, `d2` element 0 = 256, others 0, `accum`=0 → `valid` 11 cycles after start, `q`=256, `sat`=0.
- **Negative / truncation:**
  - `d1` all −256, `d2` all 8 → `q`=−2304, `sat`=0.
  - `d1` all 1, `d2` all 1 → `q`=1 (288>>>8).
- **Saturation:**
  - `d1`=`d2`= all 256 → `q`=32767, `sat`=1.
  - `d1` all −256, `d2` all 256 → `q`=−32768, `sat`=1.
- **Chaining:** run 1 with `d1`=`d2` all 16, `accum`=0 → `q`=288. Back-to-back run 2 with the same data, `accum`=1, `start` during the `valid` cycle → `q`=576, second `valid` 11 cycles after the first.
- **Handshake:** `start` pulsed at cycles 3 and 6 of a run → only one `valid`. `d1`/`d2` randomised after the start edge → `q` unaffected.
- **Reset mid-run:** `rst_n` low at cycle 5 of a run → outputs 0 immediately and no `valid`. A fresh run with the basic stimulus → `q`=256 with `accum`=1; the accumulator starts from 0.
